led_sweep_ctrl: RTL
===================

LED_SWEEP_CTRL -- requirements
Module: led_sweep_ctrl

Interface
REQ-001 Parameter DIV_BASE, default 25000000, meaning: base prescaler divisor in clk cycles per step at speed 0.
REQ-002 Parameter PW, default 32, meaning: prescaler counter width; SHALL hold DIV_BASE-1.
REQ-003 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  level; begin sweep from IDLE or resume from HOLD.
REQ-006 stop  input  1  level; pause from RUN, or clear to IDLE from HOLD.
REQ-007 mode_bounce  input  1  0 = wrap sweep 4..9,4..; 1 = bounce sweep 4..9..4.
REQ-008 speed  input  2  step-rate select; divisor = max(DIV_BASE >> speed, 1).
REQ-009 count  output  4  registered LED position code, 0 (all LEDs off) or 4..9; drives the 6-LED one-hot decoder.
REQ-010 busy  output  1  registered; 1 in RUN or HOLD.
REQ-011 cycle_done  output  1  registered one-cycle pulse at completion of each full sweep.

Function
REQ-012 FSM SHALL have states IDLE, RUN, HOLD; one-hot or binary encoding at implementer's choice.
REQ-013 IDLE: count = 0, prescaler = 0, dir = up; start=1 & stop=0 -> RUN, count = 4 on the same edge.
REQ-014 RUN: prescaler increments each cycle; when prescaler >= divisor-1 a step occurs and prescaler returns to 0.
REQ-015 Step, wrap mode: count+1, 9 -> 4; dir forced up.
REQ-016 Step, bounce mode: dir up -> count+1, at 9 dir flips down; dir down -> count-1, at 4 dir flips up (sequence 4,5,..,9,8,..,4,5,..).
REQ-017 cycle_done SHALL pulse for exactly one cycle on the edge where count changes 9 -> 4 (wrap) or 5 -> 4 (bounce); otherwise 0.
REQ-018 RUN: stop=1 -> HOLD; count, dir and prescaler frozen; no step on that edge.
REQ-019 HOLD: start=1 & stop=0 -> RUN resuming frozen count/dir/prescaler; stop=1 -> IDLE, count = 0.
REQ-020 start and stop both 1: stop SHALL win in every state; IDLE stays IDLE.
REQ-021 speed and mode_bounce SHALL be sampled every cycle; a lowered divisor with prescaler already >= divisor-1 SHALL step on the next edge.
REQ-022 Switching bounce -> wrap while dir down: next step SHALL be count+1.
REQ-023 count SHALL never leave {0,4..9}; any illegal value SHALL be forced to 4 on the next edge in RUN or HOLD.
REQ-024 busy SHALL be 1 on the edge entering RUN and 0 on the edge entering IDLE.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, count 0, dir up, prescaler 0, busy 0, cycle_done 0, independent of clk.
REQ-026 rst asserted mid-sweep SHALL discard position; after release, sweep restarts at 4 only on a new start.

Structure
REQ-027 Constants POS_MIN=4, POS_MAX=9, POS_OFF=0 and FSM state codes SHALL live in the shared LED include/package.
REQ-028 Prescaler SHALL be a sub-module led_tick_div (inputs clk, rst, en, clr, divisor; output tick); FSM and position logic stay in led_sweep_ctrl.
REQ-029 No combinational path from inputs to outputs; all outputs registered.

Verification (DIV_BASE=4)
REQ-030 Wrap, speed 0: pulse start -> count 4, then steps every 4 cycles 5,6,7,8,9,4; cycle_done high one cycle at 9->4.
REQ-031 Bounce, speed 2 (divisor 1): count 4,5,6,7,8,9,8,7,6,5,4 on consecutive steps; cycle_done at 5->4 only.
REQ-032 Pause/resume: stop at count 7 -> count holds 7 for 20 cycles, busy 1; start -> next step 8 with prescaler continuing; stop twice -> IDLE, count 0, busy 0.
REQ-033 start=stop=1 in IDLE and RUN -> stays IDLE / enters HOLD; speed 3 (divisor clamped 1) -> one step per cycle.
REQ-034 Async rst asserted between clk edges at count 8 -> count 0, busy 0 before next edge; no activity until new start.
REQ-035 Bounce dir down at count 6, switch mode_bounce to 0 -> next step count 7, then 8, 9, 4.

Source files
------------

// File: rtl/led_sweep_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// led_sweep_ctrl_pkg
// Shared constants and types for the LED sweep controller.
//   POS_OFF / POS_MIN / POS_MAX : position codes seen by the 6-LED decoder
//   sweep_state_t               : controller FSM states
//   sweep_dir_t                 : sweep direction used in bounce mode
//   pos_legal()                 : true for an active sweep position (4..9)
// -----------------------------------------------------------------------------
package led_sweep_ctrl_pkg;

    localparam logic [3:0] POS_OFF = 4'd0;
    localparam logic [3:0] POS_MIN = 4'd4;
    localparam logic [3:0] POS_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } sweep_state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } sweep_dir_t;

    function automatic logic pos_legal(input logic [3:0] pos);
        return (pos >= POS_MIN) && (pos <= POS_MAX);
    endfunction

endpackage

// File: rtl/led_sweep_ctrl_if.sv
// -----------------------------------------------------------------------------
// led_sweep_ctrl_if
// Control/status bundle of the LED sweep controller.
//   start, stop   : level requests to run / pause / clear
//   mode_bounce   : 0 = wrap sweep, 1 = bounce sweep
//   speed         : step-rate select (divisor = base >> speed, minimum 1)
//   count         : LED position code (0 or 4..9)
//   busy          : controller is running or paused
//   cycle_done    : one-cycle pulse at the end of each full sweep
// master drives the requests, slave (the controller) drives the status.
// -----------------------------------------------------------------------------
interface led_sweep_ctrl_if;

    logic       start;
    logic       stop;
    logic       mode_bounce;
    logic [1:0] speed;
    logic [3:0] count;
    logic       busy;
    logic       cycle_done;

    modport master (
        output start, stop, mode_bounce, speed,
        input  count, busy, cycle_done
    );

    modport slave (
        input  start, stop, mode_bounce, speed,
        output count, busy, cycle_done
    );

endinterface

// File: rtl/led_tick_div.sv
// -----------------------------------------------------------------------------
// led_tick_div
// Step prescaler. Counts enabled cycles and flags a tick on the cycle where
// the count has reached divisor-1, returning to 0 on that edge.
//   clk, rst : clock, asynchronous active-high reset
//   en       : count this cycle (counter frozen when low)
//   clr      : synchronous clear to 0 (overrides en)
//   divisor  : cycles per tick, expected >= 1
//   tick     : high during the cycle whose edge performs a step
// -----------------------------------------------------------------------------
module led_tick_div #(
    parameter int PW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic [PW-1:0] divisor,
    output logic          tick
);

    logic [PW-1:0] cnt;
    logic          at_limit;

    // Compare with >= so that a divisor lowered below the current count
    // still produces a tick on the very next edge instead of wrapping around.
    assign at_limit = (cnt >= (divisor - PW'(1)));
    assign tick     = en && at_limit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= at_limit ? '0 : cnt + PW'(1);
        end
    end

endmodule

// File: rtl/led_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// led_sweep_ctrl
// Sweeps an LED position code across 4..9 either as a wrapping ramp or as a
// bouncing back-and-forth pattern, with run / pause / clear control.
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : led_sweep_ctrl_if.slave (start, stop, mode_bounce, speed in;
//          count, busy, cycle_done out, all registered)
// Parameters:
//   DIV_BASE : clk cycles per step at speed 0
//   PW       : prescaler width, must hold DIV_BASE-1
// -----------------------------------------------------------------------------
module led_sweep_ctrl #(
    parameter int DIV_BASE = 25000000,
    parameter int PW       = 32
) (
    input  logic              clk,
    input  logic              rst,
    led_sweep_ctrl_if.slave   bus
);

    import led_sweep_ctrl_pkg::*;

    sweep_state_t  state, state_next;
    sweep_dir_t    dir, dir_next;
    logic [3:0]    count_next;
    logic          done_next;
    logic          busy_next;
    logic          step_up;

    logic [PW-1:0] div_shift;
    logic [PW-1:0] divisor;
    logic          tick;
    logic          div_en;
    logic          div_clr;

    // Faster speeds shift the base divisor down; clamp at 1 so the top
    // speed settings degrade to one step per cycle rather than stalling.
    assign div_shift = PW'(DIV_BASE) >> bus.speed;
    assign divisor   = (div_shift == '0) ? PW'(1) : div_shift;

    // The prescaler only advances while actually running; a stop request in
    // RUN freezes it on the same edge. It is zeroed whenever we are, or are
    // about to be, idle.
    assign div_en  = (state == ST_RUN) && !bus.stop;
    assign div_clr = (state == ST_IDLE) || ((state == ST_HOLD) && bus.stop);

    led_tick_div #(
        .PW (PW)
    ) u_tick_div (
        .clk     (clk),
        .rst     (rst),
        .en      (div_en),
        .clr     (div_clr),
        .divisor (divisor),
        .tick    (tick)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus next position/direction/pulse. Stop always wins over
    // start. A position that is somehow outside 4..9 while active is pulled
    // back to 4 before any stepping is attempted.
    always_comb begin
        state_next = state;
        count_next = bus.count;
        dir_next   = dir;
        done_next  = 1'b0;
        step_up    = 1'b0;

        case (state)
            ST_IDLE: begin
                count_next = POS_OFF;
                dir_next   = DIR_UP;
                if (bus.start && !bus.stop) begin
                    state_next = ST_RUN;
                    count_next = POS_MIN;
                end
            end

            ST_RUN: begin
                if (bus.stop) begin
                    state_next = ST_HOLD;
                    if (!pos_legal(bus.count)) begin
                        count_next = POS_MIN;
                    end
                end else if (!pos_legal(bus.count)) begin
                    count_next = POS_MIN;
                end else if (tick) begin
                    if (bus.mode_bounce) begin
                        // Leaving wrap mode can leave dir stale; the ends of
                        // the range always force the only legal direction.
                        step_up = ((dir == DIR_UP) && (bus.count != POS_MAX)) ||
                                  (bus.count == POS_MIN);
                        if (step_up) begin
                            count_next = bus.count + 4'd1;
                            dir_next   = (count_next == POS_MAX) ? DIR_DOWN : DIR_UP;
                        end else begin
                            count_next = bus.count - 4'd1;
                            dir_next   = (count_next == POS_MIN) ? DIR_UP : DIR_DOWN;
                            done_next  = (count_next == POS_MIN);
                        end
                    end else begin
                        dir_next   = DIR_UP;
                        done_next  = (bus.count == POS_MAX);
                        count_next = (bus.count == POS_MAX) ? POS_MIN : bus.count + 4'd1;
                    end
                end
            end

            ST_HOLD: begin
                if (bus.stop) begin
                    state_next = ST_IDLE;
                    count_next = POS_OFF;
                    dir_next   = DIR_UP;
                end else begin
                    if (bus.start) begin
                        state_next = ST_RUN;
                    end
                    if (!pos_legal(bus.count)) begin
                        count_next = POS_MIN;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
                count_next = POS_OFF;
                dir_next   = DIR_UP;
            end
        endcase

        busy_next = (state_next != ST_IDLE);
    end

    // Registered outputs and sweep direction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.count      <= POS_OFF;
            bus.busy       <= 1'b0;
            bus.cycle_done <= 1'b0;
            dir            <= DIR_UP;
        end else begin
            bus.count      <= count_next;
            bus.busy       <= busy_next;
            bus.cycle_done <= done_next;
            dir            <= dir_next;
        end
    end

endmodule
